// File: rtl/operand_mux_pipe.sv
// N-way operand select with a registered valid/ready output stage.
// A main register drives the outputs and a skid register absorbs one beat of backpressure.
module operand_mux_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH*NUM_IN-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        xfer_cnt
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_err_q, m_err_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             s_err_q, s_err_d;
    logic             s_valid_q, s_valid_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic it;
    logic ot;

    // Any select with no matching channel falls through as an error beat with zero data.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    assign in_ready = rst_n && !s_valid_q;
    assign it       = in_valid && in_ready;
    assign ot       = m_valid_q && out_ready;

    always_comb begin
        m_data_d   = m_data_q;
        m_err_d    = m_err_q;
        m_valid_d  = m_valid_q;
        s_data_d   = s_data_q;
        s_err_d    = s_err_q;
        s_valid_d  = s_valid_q;
        xfer_cnt_d = xfer_cnt_q + CNT_W'(ot);

        if (ot && s_valid_q) begin
            m_data_d  = s_data_q;
            m_err_d   = s_err_q;
            s_valid_d = 1'b0;
        end else if (it && (!m_valid_q || ot)) begin
            m_data_d  = sel_data;
            m_err_d   = sel_err;
            m_valid_d = 1'b1;
        end else if (it) begin
            // M is full and stalled: park the beat so in_ready can fall from a register.
            s_data_d  = sel_data;
            s_err_d   = sel_err;
            s_valid_d = 1'b1;
        end else if (ot) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data_q   <= '0;
            m_err_q    <= 1'b0;
            m_valid_q  <= 1'b0;
            s_data_q   <= '0;
            s_err_q    <= 1'b0;
            s_valid_q  <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            m_data_q   <= m_data_d;
            m_err_q    <= m_err_d;
            m_valid_q  <= m_valid_d;
            s_data_q   <= s_data_d;
            s_err_q    <= s_err_d;
            s_valid_q  <= s_valid_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign out_data    = m_data_q;
    assign out_sel_err = m_err_q;
    assign out_valid   = m_valid_q;
    assign xfer_cnt    = xfer_cnt_q;

endmodule

// File: doc/operand_mux_pipe.md
Name: operand_mux_pipe

Overview:
Parametrised N-way operand select multiplexer with a registered, valid/ready-handshaked output stage for the processor datapath. It supersedes the plain 2:1 byte select with:
- configurable data width and input count;
- one-cycle registered latency;
- a two-entry skid buffer, so full throughput holds with registered backpressure;
- out-of-range select detection;
- a wrapping output-transfer counter.

It sits between register-file/forwarding sources and the ALU operand input.

Parameters:
WIDTH, 8, data width of every input channel and of the output
NUM_IN, 4, number of input channels (2..16)
SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN
CNT_W, 8, width of the output-transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on clk rising edge
in_data  input  WIDTH*NUM_IN  flattened channels; channel k = in_data[k*WIDTH +: WIDTH]
in_sel  input  SEL_W  channel select
in_valid  input  1  upstream offers in_data/in_sel
in_ready  output  1  block can accept this cycle
out_data  output  WIDTH  selected data
out_sel_err  output  1  in_sel was >= NUM_IN for this beat
out_valid  output  1  out_data/out_sel_err valid
out_ready  input  1  downstream accepts this cycle
xfer_cnt  output  CNT_W  count of completed output transfers

Behaviour:
- Transfers:
  - Input transfer (IT) when in_valid && in_ready at a rising edge.
  - Output transfer (OT) when out_valid && out_ready at a rising edge.
- Select and capture:
  - Select is evaluated combinationally on the IT cycle. The result (data, err) is captured.
  - in_sel < NUM_IN gives data = channel in_sel, err = 0.
  - in_sel >= NUM_IN gives data = 0, err = 1. The beat is still passed downstream, not dropped.
- Storage: main register M (drives out_*) and skid register S, each with its own valid bit.
- in_ready = rst_n && !S.valid. Combinational from the registered S.valid and rst_n only; no path from in_valid or out_ready.
- Per-edge update (rst_n high):
  - M empty, or OT this cycle, with S empty, and IT: M <- new beat.
  - M full, no OT, and IT: S <- new beat. in_ready drops next cycle.
  - OT and S full: M <- S, S cleared. in_ready rises next cycle. No IT is possible in this case (in_ready was 0).
  - OT, S empty, no IT: M.valid <- 0.
  - Otherwise hold. Data in M stays stable while out_valid && !out_ready.
- Latency: one cycle from IT to out_valid when the block is empty.
- Throughput: one beat per cycle under continuous out_ready.
- Ordering: beats leave in acceptance order. No beat is lost or duplicated.
- xfer_cnt increments by 1 on every OT and wraps modulo 2^CNT_W (255 -> 0 for CNT_W=8).
- Reset (rst_n low at an edge):
  - M.valid = S.valid = 0, out_data = 0, out_sel_err = 0, xfer_cnt = 0.
  - in_ready = 0 while rst_n is low. Inputs are ignored.
- Reset mid-operation discards both held beats. No OT is counted on the reset edge.
- First IT is possible on the first edge with rst_n high. in_ready is 1 during that cycle.
- out_ready may be asserted with out_valid low; no effect.
- Upstream may change in_data/in_sel freely while in_ready is 0.

Test Plan:
1. Reset, then single beat: in_data = {8'h44, 8'h33, 8'h22, 8'h11}, in_sel = 2, in_valid for 1 cycle, out_ready = 1 -> next cycle out_valid = 1, out_data = 8'h33, out_sel_err = 0; xfer_cnt = 1 after the OT.
2. Stream sel = 0,1,2,3,0 on consecutive cycles, out_ready = 1 -> out_data 11,22,33,44,11 on consecutive cycles; in_ready stays 1; xfer_cnt = 5.
3. Backpressure: out_ready = 0, offer beats A (sel 0), B (sel 1), C (sel 2) back-to-back ->
   - A and B accepted; in_ready = 0 from the cycle after B; C held upstream; out_data = 11, stable.
   - out_ready = 1 -> outputs 11, 22, 33 in order, no gaps after release.
4. Out-of-range with WIDTH = 8, NUM_IN = 3, SEL_W = 2: in_sel = 3 -> out_data = 0, out_sel_err = 1; next beat sel = 1 -> err = 0, correct data.
5. Counter wrap: 256 OTs with CNT_W = 8 -> xfer_cnt reads 255 then 0.
6. Reset mid-operation: M and S both full (out_ready = 0), assert rst_n = 0 for one edge ->
   - out_valid = 0, in_ready = 0 during reset, xfer_cnt = 0;
   - after release, new beat sel = 3 -> out_data = 8'h44 only, no stale beats.
